// File: rtl/alu_opcodes_pkg.sv
// ALU opcode encoding shared by decoder, issue queue and execute unit,
// plus the request bundle that travels from decode to the ALU.
package alu_opcodes_pkg;

   typedef enum logic [4:0] {
      ALU_ADD  = 5'd0,
      ALU_SUB  = 5'd1,
      ALU_XOR  = 5'd2,
      ALU_OR   = 5'd3,
      ALU_AND  = 5'd4,
      ALU_SLL  = 5'd5,
      ALU_SRL  = 5'd6,
      ALU_SRA  = 5'd7,
      ALU_SLT  = 5'd8,
      ALU_SLTU = 5'd9
   } alu_op_e;

   // Opcode kept as raw bits so unknown encodings pass through untouched.
   typedef struct packed {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
   } alu_req_t;

endpackage

// File: rtl/alu_issue_queue_if.sv
// Decode-side and ALU-side handshakes of the ALU issue queue.
// master: request producer / result consumer; slave: the queue.
interface alu_issue_queue_if #(
   parameter int unsigned TAG_W = 5
);
   logic             in_valid_i;
   logic             in_ready_o;
   logic [4:0]       in_op_i;
   logic [31:0]      in_a_i;
   logic [31:0]      in_b_i;
   logic [TAG_W-1:0] in_tag_i;

   logic             out_valid_o;
   logic             out_ready_i;
   logic [4:0]       alu_op_o;
   logic [31:0]      a_o;
   logic [31:0]      b_o;
   logic [TAG_W-1:0] tag_o;

   modport master (
      output in_valid_i, in_op_i, in_a_i, in_b_i, in_tag_i, out_ready_i,
      input  in_ready_o, out_valid_o, alu_op_o, a_o, b_o, tag_o
   );

   modport slave (
      input  in_valid_i, in_op_i, in_a_i, in_b_i, in_tag_i, out_ready_i,
      output in_ready_o, out_valid_o, alu_op_o, a_o, b_o, tag_o
   );
endinterface

// File: rtl/alu_issue_queue_issue_fifo_mem.sv
// Entry storage for the ALU issue queue: DEPTH x WIDTH register array,
// one synchronous write port, one combinational read port.
module issue_fifo_mem #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];

   // Write port: contents need no reset, validity is tracked by the owner.
   always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/alu_issue_queue.sv
// In-order request buffer between decoder and ALU with flush support.
// Optional macro ALU_ISSUE_BYPASS_EN: an empty queue forwards the input
// beat combinationally to the ALU side.
module alu_issue_queue
   import alu_opcodes_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned TAG_W = 5
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   flush_i,
   alu_issue_queue_if.slave       bus,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef struct packed {
      alu_req_t         req;
      logic [TAG_W-1:0] tag;
   } entry_t;

   logic [AW-1:0] wptr_q, rptr_q;
   logic [CW-1:0] count_q;
   entry_t        in_ent, head_ent, out_ent;
   logic          empty, in_ready, bypass, out_valid;
   logic          push, pop, mem_we, mem_pop;

   assign in_ent.req.op = bus.in_op_i;
   assign in_ent.req.a  = bus.in_a_i;
   assign in_ent.req.b  = bus.in_b_i;
   assign in_ent.tag    = bus.in_tag_i;

   assign empty    = (count_q == '0);
   assign in_ready = (count_q < FULL);

`ifdef ALU_ISSUE_BYPASS_EN
   assign bypass = empty && bus.in_valid_i && !flush_i;
`else
   assign bypass = 1'b0;
`endif

   assign out_valid = !flush_i && (!empty || bypass);
   assign push      = bus.in_valid_i && in_ready && !flush_i;
   assign pop       = out_valid && bus.out_ready_i && !flush_i;
   // A bypassed beat that is consumed immediately never touches storage,
   // and a pop from an empty queue can only be that bypassed beat.
   assign mem_we    = push && !(bypass && bus.out_ready_i);
   assign mem_pop   = pop && !empty;

   // Pointer and occupancy update; reset and flush both empty the queue.
   always_ff @(posedge clk_i) begin
      if (!rst_ni || flush_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (mem_we)  wptr_q <= wptr_q + AW'(1);
         if (mem_pop) rptr_q <= rptr_q + AW'(1);
         count_q <= count_q + CW'(mem_we) - CW'(mem_pop);
      end
   end

   issue_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(entry_t))
   ) u_mem (
      .clk_i   (clk_i),
      .we_i    (mem_we),
      .waddr_i (wptr_q),
      .wdata_i (in_ent),
      .raddr_i (rptr_q),
      .rdata_o (head_ent)
   );

   // Head selection; outputs are forced to zero while nothing is valid.
   always_comb begin
      out_ent = '0;
      if (out_valid) out_ent = bypass ? in_ent : head_ent;
   end

   assign bus.in_ready_o  = in_ready;
   assign bus.out_valid_o = out_valid;
   assign bus.alu_op_o    = out_ent.req.op;
   assign bus.a_o         = out_ent.req.a;
   assign bus.b_o         = out_ent.req.b;
   assign bus.tag_o       = out_ent.tag;
   assign count_o         = count_q;
endmodule

// File: tb/tb_alu_issue_queue.sv
// Self-checking bench for alu_issue_queue: queue-based reference model
// compared every cycle, directed scenarios with literal expectations,
// then randomized traffic with flushes and resets.
module tb_alu_issue_queue;
   import alu_opcodes_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned TAG_W = 5;
`ifdef ALU_ISSUE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef struct packed {
      logic [4:0]       op;
      logic [31:0]      a;
      logic [31:0]      b;
      logic [TAG_W-1:0] tag;
   } ent_t;

   logic       clk = 1'b0;
   logic       rst_ni;
   logic       flush_i;
   logic [2:0] count;

   alu_issue_queue_if #(.TAG_W(TAG_W)) bus ();

   alu_issue_queue #(
      .DEPTH (DEPTH),
      .TAG_W (TAG_W)
   ) dut (
      .clk_i   (clk),
      .rst_ni  (rst_ni),
      .flush_i (flush_i),
      .bus     (bus),
      .count_o (count)
   );

   always #5 clk = ~clk;

   int   vectors    = 0;
   int   miscompares = 0;
   bit   chk_en     = 1'b0;
   bit   acc_prev   = 1'b0;
   ent_t mq[$];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: expected outputs from queue contents, then next state.
   ent_t m_in, m_head;
   int   m_cnt;
   bit   m_ready, m_byp, m_valid, m_push, m_pop;
   always @(negedge clk) begin
      if (chk_en) begin
         m_in    = {bus.in_op_i, bus.in_a_i, bus.in_b_i, bus.in_tag_i};
         m_cnt   = mq.size();
         m_ready = (m_cnt < DEPTH);
         m_byp   = BYP && (m_cnt == 0) && bus.in_valid_i && !flush_i;
         m_valid = !flush_i && ((m_cnt != 0) || m_byp);
         m_head  = '0;
         if (m_valid) m_head = (m_cnt != 0) ? mq[0] : m_in;
         check("in_ready",  32'(bus.in_ready_o),  32'(m_ready));
         check("out_valid", 32'(bus.out_valid_o), 32'(m_valid));
         check("alu_op",    32'(bus.alu_op_o),    32'(m_head.op));
         check("a",         bus.a_o,              m_head.a);
         check("b",         bus.b_o,              m_head.b);
         check("tag",       32'(bus.tag_o),       32'(m_head.tag));
         check("count",     32'(count),           32'(m_cnt));
         acc_prev = bus.in_valid_i && (!rst_ni || flush_i || m_ready);
         if (!rst_ni || flush_i) begin
            mq.delete();
         end else begin
            m_push = bus.in_valid_i && m_ready;
            m_pop  = m_valid && bus.out_ready_i;
            if (m_pop && m_cnt != 0) void'(mq.pop_front());
            if (m_push && !(m_pop && m_cnt == 0)) mq.push_back(m_in);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [TAG_W-1:0] tag);
      bus.in_valid_i = v;
      bus.in_op_i    = op;
      bus.in_a_i     = a;
      bus.in_b_i     = b;
      bus.in_tag_i   = tag;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni  = 1'b0;
      flush_i = 1'b0;
      bus.out_ready_i = 1'b0;
      drive(1'b0, 5'd0, 32'd0, 32'd0, '0);
      @(posedge clk); #1;
      chk_en = 1'b1;
      tick();
      rst_ni = 1'b1;
      #1;
      check("rst_in_ready",  32'(bus.in_ready_o),  32'd1);
      check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
      check("rst_count",     32'(count),           32'd0);
      check("rst_a",         bus.a_o,              32'd0);

      // Single push, stall, pop.
      drive(1'b1, ALU_ADD, 32'd5, 32'd7, 5'd3);
      tick();
      bus.in_valid_i = 1'b0;
      #1;
      check("push_valid", 32'(bus.out_valid_o), 32'd1);
      check("push_a",     bus.a_o,              32'd5);
      check("push_b",     bus.b_o,              32'd7);
      check("push_tag",   32'(bus.tag_o),       32'd3);
      check("push_count", 32'(count),           32'd1);
      repeat (3) begin
         tick(); #1;
         check("stall_a",   bus.a_o,        32'd5);
         check("stall_tag", 32'(bus.tag_o), 32'd3);
      end
      bus.out_ready_i = 1'b1;
      tick();
      bus.out_ready_i = 1'b0;
      #1;
      check("pop_count", 32'(count),           32'd0);
      check("pop_valid", 32'(bus.out_valid_o), 32'd0);

      // Fill to full, hold a fifth beat, drain across pointer wrap.
      for (int t = 1; t <= 4; t++) begin
         drive(1'b1, ALU_SUB, 32'(t * 100), 32'(t), 5'(t));
         tick();
      end
      drive(1'b1, ALU_XOR, 32'd500, 32'd5, 5'd5);
      #1;
      check("full_count", 32'(count),          32'd4);
      check("full_ready", 32'(bus.in_ready_o), 32'd0);
      tick(); #1;
      check("full_hold_count", 32'(count),     32'd4);
      check("order_tag1", 32'(bus.tag_o), 32'd1);
      bus.out_ready_i = 1'b1;
      tick(); #1;
      check("order_tag2", 32'(bus.tag_o), 32'd2);
      tick();
      bus.in_valid_i = 1'b0;
      #1;
      check("order_tag3",  32'(bus.tag_o), 32'd3);
      check("order_count", 32'(count),     32'd3);
      tick(); #1;
      check("order_tag4", 32'(bus.tag_o), 32'd4);
      tick(); #1;
      check("order_tag5", 32'(bus.tag_o), 32'd5);
      check("order_a5",   bus.a_o,        32'd500);
      tick();
      bus.out_ready_i = 1'b0;
      #1;
      check("drain_count", 32'(count), 32'd0);

      // Sustained push+pop at occupancy 2.
      drive(1'b1, ALU_AND, 32'd10, 32'd0, 5'd10); tick();
      drive(1'b1, ALU_AND, 32'd11, 32'd0, 5'd11); tick();
      bus.out_ready_i = 1'b1;
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, ALU_OR, 32'(12 + i), 32'(i), 5'(12 + i));
         #1;
         check("stream_tag",   32'(bus.tag_o), 32'(10 + i));
         check("stream_count", 32'(count),     32'd2);
         tick();
      end
      bus.in_valid_i = 1'b0;
      tick(); tick();
      bus.out_ready_i = 1'b0;
      #1;
      check("stream_drain", 32'(count), 32'd0);

      // Flush with a beat on the input.
      for (int t = 20; t <= 22; t++) begin
         drive(1'b1, ALU_SLL, 32'(t), 32'd1, 5'(t));
         tick();
      end
      flush_i = 1'b1;
      drive(1'b1, ALU_SRL, 32'd99, 32'd9, 5'd9);
      #1;
      check("flush_pre_count", 32'(count),           32'd3);
      check("flush_valid",     32'(bus.out_valid_o), 32'd0);
      tick();
      flush_i = 1'b0;
      bus.in_valid_i = 1'b0;
      #1;
      check("flush_count", 32'(count),           32'd0);
      check("flush_post",  32'(bus.out_valid_o), 32'd0);

      // Empty queue, beat with consumer ready.
      drive(1'b1, ALU_SLT, 32'd66, 32'd6, 5'd6);
      bus.out_ready_i = 1'b1;
      #1;
      if (BYP) begin
         check("byp_valid", 32'(bus.out_valid_o), 32'd1);
         check("byp_tag",   32'(bus.tag_o),       32'd6);
         tick();
         bus.in_valid_i = 1'b0;
         #1;
         check("byp_count", 32'(count), 32'd0);
      end else begin
         check("nobyp_valid0", 32'(bus.out_valid_o), 32'd0);
         tick();
         bus.in_valid_i = 1'b0;
         #1;
         check("nobyp_tag",   32'(bus.tag_o), 32'd6);
         check("nobyp_count", 32'(count),     32'd1);
         tick(); #1;
         check("nobyp_drain", 32'(count), 32'd0);
      end
      bus.out_ready_i = 1'b0;

      // Randomized traffic; held beats respect the valid/ready protocol.
      for (int i = 0; i < 3000; i++) begin
         if (!(bus.in_valid_i && !acc_prev)) begin
            drive(1'($urandom_range(0, 2) != 0), 5'($urandom), $urandom, $urandom,
                  TAG_W'($urandom));
         end
         bus.out_ready_i = (i < 1500) ? 1'($urandom_range(0, 3) != 0)
                                      : 1'($urandom_range(0, 3) == 0);
         flush_i = 1'($urandom_range(0, 40) == 0);
         rst_ni  = 1'($urandom_range(0, 150) != 0);
         tick();
      end
      rst_ni  = 1'b1;
      flush_i = 1'b0;
      bus.in_valid_i  = 1'b0;
      bus.out_ready_i = 1'b1;
      repeat (8) tick();
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
